// File: rtl/obi_pkg.sv
// Shared OBI bus widths, request-field bundle and default memory-map decode values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package obi_pkg;

   localparam int OBI_AW  = 32;
   localparam int OBI_DW  = 32;
   localparam int OBI_BEW = 4;

   // Request payload carried from the winning master to a slave
   typedef struct packed {
      logic               we;
      logic [OBI_BEW-1:0] be;
      logic [OBI_AW-1:0]  addr;
      logic [OBI_DW-1:0]  wdata;
   } obi_req_t;

   // Default decode windows: ROM at 0x0xxx_xxxx, RAM at 0x1xxx_xxxx
   localparam logic [OBI_AW-1:0] ROM_ADDR_BASE = 32'h0000_0000;
   localparam logic [OBI_AW-1:0] ROM_ADDR_MASK = 32'hF000_0000;
   localparam logic [OBI_AW-1:0] RAM_ADDR_BASE = 32'h1000_0000;
   localparam logic [OBI_AW-1:0] RAM_ADDR_MASK = 32'hF000_0000;

endpackage

// File: rtl/obi_prio_arb.sv
// Fixed-priority arbiter: lowest requesting index wins.
// Latency: combinational, 0 cycles.
// Backpressure: none internally; losers simply see no grant and must hold.
// Ports: i_req[N] requests in; o_gnt[N] one-hot grant; o_idx winner index; o_vld any winner.
module obi_prio_arb #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_vld
);

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i_req[i] && !o_vld) begin
            o_gnt[i] = 1'b1;
            o_idx    = IW'(i);
            o_vld    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/obi_xbar.sv
// MASTERS x SLAVES OBI crossbar: address decode, per-slave fixed-priority arbitration, response routing.
// Latency: request path combinational; response delivered the cycle the slave returns rvalid (miss: 1 cycle).
// Backpressure: master gnt follows slave gnt combinationally; arbitration losers get gnt=0 and hold.
// Ports: clk_i/rst_i; master_* request/response per master; slave_addr_mask_i/base_i decode window;
//        slave_* request out / gnt, rvalid, rdata in per slave.
module obi_xbar
   import obi_pkg::*;
#(
   parameter int MASTERS = 2,
   parameter int SLAVES  = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [MASTERS-1:0]                master_req_i,
   output logic [MASTERS-1:0]                master_gnt_o,
   output logic [MASTERS-1:0]                master_rvalid_o,
   input  logic [MASTERS-1:0]                master_we_i,
   input  logic [MASTERS-1:0][OBI_BEW-1:0]   master_be_i,
   input  logic [MASTERS-1:0][OBI_AW-1:0]    master_addr_i,
   input  logic [MASTERS-1:0][OBI_DW-1:0]    master_wdata_i,
   output logic [MASTERS-1:0][OBI_DW-1:0]    master_rdata_o,
   input  logic [SLAVES-1:0][OBI_AW-1:0]     slave_addr_mask_i,
   input  logic [SLAVES-1:0][OBI_AW-1:0]     slave_addr_base_i,
   output logic [SLAVES-1:0]                 slave_req_o,
   input  logic [SLAVES-1:0]                 slave_gnt_i,
   input  logic [SLAVES-1:0]                 slave_rvalid_i,
   output logic [SLAVES-1:0]                 slave_we_o,
   output logic [SLAVES-1:0][OBI_BEW-1:0]    slave_be_o,
   output logic [SLAVES-1:0][OBI_AW-1:0]     slave_addr_o,
   output logic [SLAVES-1:0][OBI_DW-1:0]     slave_wdata_o,
   input  logic [SLAVES-1:0][OBI_DW-1:0]     slave_rdata_i
);

   localparam int MIW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

   logic [MASTERS-1:0][SLAVES-1:0]  w_sel;
   logic [MASTERS-1:0]              w_miss;
   obi_req_t [MASTERS-1:0]          w_mreq;
   obi_req_t [SLAVES-1:0]           w_sreq;
   logic [SLAVES-1:0][MASTERS-1:0]  w_slv_req;
   logic [SLAVES-1:0][MASTERS-1:0]  w_arb_gnt;
   logic [SLAVES-1:0][MIW-1:0]      w_arb_idx;
   logic [SLAVES-1:0]               w_arb_vld;
   logic [SLAVES-1:0]               w_hs;

   logic [SLAVES-1:0]               r_pend;
   logic [SLAVES-1:0][MIW-1:0]      r_idx;
   logic [MASTERS-1:0]              r_miss;

   // Decode: w_miss doubles as "no match yet" so the lowest matching slave wins
   always_comb begin
      w_sel     = '0;
      w_miss    = '1;
      w_mreq    = '0;
      w_slv_req = '0;
      for (int m = 0; m < MASTERS; m++) begin
         w_mreq[m] = '{we: master_we_i[m], be: master_be_i[m],
                       addr: master_addr_i[m], wdata: master_wdata_i[m]};
         for (int s = 0; s < SLAVES; s++) begin
            if (w_miss[m] && ((master_addr_i[m] & slave_addr_mask_i[s]) == slave_addr_base_i[s])) begin
               w_sel[m][s] = 1'b1;
               w_miss[m]   = 1'b0;
            end
         end
         for (int s = 0; s < SLAVES; s++) begin
            w_slv_req[s][m] = master_req_i[m] & w_sel[m][s];
         end
      end
   end

   for (genvar s = 0; s < SLAVES; s++) begin : g_arb
      obi_prio_arb #(.N(MASTERS), .IW(MIW)) u_arb (
         .i_req (w_slv_req[s]),
         .o_gnt (w_arb_gnt[s]),
         .o_idx (w_arb_idx[s]),
         .o_vld (w_arb_vld[s])
      );
   end

   // Forward the winner's payload; everything stays 0 without a winner
   always_comb begin
      w_sreq        = '0;
      slave_req_o   = '0;
      slave_we_o    = '0;
      slave_be_o    = '0;
      slave_addr_o  = '0;
      slave_wdata_o = '0;
      w_hs          = '0;
      for (int s = 0; s < SLAVES; s++) begin
         for (int m = 0; m < MASTERS; m++) begin
            if (w_arb_gnt[s][m]) w_sreq[s] = w_mreq[m];
         end
         slave_req_o[s]   = w_arb_vld[s];
         slave_we_o[s]    = w_sreq[s].we;
         slave_be_o[s]    = w_sreq[s].be;
         slave_addr_o[s]  = w_sreq[s].addr;
         slave_wdata_o[s] = w_sreq[s].wdata;
         w_hs[s]          = w_arb_vld[s] & slave_gnt_i[s];
      end
   end

   // Decode misses are accepted on the spot; slave hits take the slave's gnt
   always_comb begin
      master_gnt_o = master_req_i & w_miss;
      for (int s = 0; s < SLAVES; s++) begin
         for (int m = 0; m < MASTERS; m++) begin
            master_gnt_o[m] = master_gnt_o[m] | (w_arb_gnt[s][m] & slave_gnt_i[s]);
         end
      end
   end

   // A same-cycle grant reloads pend, so back-to-back traffic never loses a response
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pend <= '0;
         r_idx  <= '0;
         r_miss <= '0;
      end else begin
         for (int s = 0; s < SLAVES; s++) begin
            if (w_hs[s]) begin
               r_pend[s] <= 1'b1;
               r_idx[s]  <= w_arb_idx[s];
            end else if (slave_rvalid_i[s]) begin
               r_pend[s] <= 1'b0;
            end
         end
         r_miss <= master_req_i & w_miss;
      end
   end

   // Response routing; a miss response carries rdata 0, unmatched rvalids are dropped
   always_comb begin
      master_rvalid_o = r_miss;
      master_rdata_o  = '0;
      for (int s = 0; s < SLAVES; s++) begin
         for (int m = 0; m < MASTERS; m++) begin
            if (r_pend[s] && slave_rvalid_i[s] && (r_idx[s] == MIW'(m))) begin
               master_rvalid_o[m] = 1'b1;
               master_rdata_o[m]  = master_rdata_o[m] | slave_rdata_i[s];
            end
         end
      end
   end

endmodule

// File: tb/tb_obi_xbar.sv
// Directed bench for obi_xbar with ROM/RAM slave models (gnt = req, 1-cycle registered rvalid).
// Inputs change 1 time unit after posedge; outputs are sampled a few units later.
module tb_obi_xbar;
   import obi_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               mrst;
   logic [1:0]         master_req;
   logic [1:0]         master_gnt;
   logic [1:0]         master_rvalid;
   logic [1:0]         master_we;
   logic [1:0][3:0]    master_be;
   logic [1:0][31:0]   master_addr;
   logic [1:0][31:0]   master_wdata;
   logic [1:0][31:0]   master_rdata;
   logic [1:0][31:0]   slave_mask;
   logic [1:0][31:0]   slave_base;
   logic [1:0]         slave_req;
   logic [1:0]         slave_gnt;
   logic [1:0]         gnt_block;
   logic [1:0]         s_rvalid;
   logic [1:0]         slave_we;
   logic [1:0][3:0]    slave_be;
   logic [1:0][31:0]   slave_addr;
   logic [1:0][31:0]   slave_wdata;
   logic [1:0][31:0]   s_rdata;
   logic [31:0]        mem [0:1][0:15];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   obi_xbar #(.MASTERS(2), .SLAVES(2)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .master_req_i      (master_req),
      .master_gnt_o      (master_gnt),
      .master_rvalid_o   (master_rvalid),
      .master_we_i       (master_we),
      .master_be_i       (master_be),
      .master_addr_i     (master_addr),
      .master_wdata_i    (master_wdata),
      .master_rdata_o    (master_rdata),
      .slave_addr_mask_i (slave_mask),
      .slave_addr_base_i (slave_base),
      .slave_req_o       (slave_req),
      .slave_gnt_i       (slave_gnt),
      .slave_rvalid_i    (s_rvalid),
      .slave_we_o        (slave_we),
      .slave_be_o        (slave_be),
      .slave_addr_o      (slave_addr),
      .slave_wdata_o     (slave_wdata),
      .slave_rdata_i     (s_rdata)
   );

   // Slave 0 = ROM preloaded with 0xA000_0000 + word index, slave 1 = zeroed RAM
   assign slave_gnt = slave_req & ~gnt_block;

   always @(posedge clk or posedge mrst) begin
      if (mrst) begin
         for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
               mem[s][w] <= (s == 0) ? (32'hA000_0000 + 32'(w)) : 32'h0;
            end
         end
         s_rvalid <= '0;
         s_rdata  <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            s_rvalid[s] <= slave_req[s] & slave_gnt[s];
            if (slave_req[s] && slave_gnt[s]) begin
               s_rdata[s] <= mem[s][slave_addr[s][5:2]];
               if (slave_we[s]) begin
                  for (int b = 0; b < 4; b++) begin
                     if (slave_be[s][b]) mem[s][slave_addr[s][5:2]][8*b +: 8] <= slave_wdata[s][8*b +: 8];
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int m, input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata);
      master_req[m]   = req;
      master_we[m]    = we;
      master_be[m]    = be;
      master_addr[m]  = addr;
      master_wdata[m] = wdata;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_d;
      rst          = 1'b1;
      mrst         = 1'b1;
      gnt_block    = '0;
      master_req   = '0;
      master_we    = '0;
      master_be    = '0;
      master_addr  = '0;
      master_wdata = '0;
      slave_mask   = {RAM_ADDR_MASK, ROM_ADDR_MASK};
      slave_base   = {RAM_ADDR_BASE, ROM_ADDR_BASE};
      #12;
      mrst = 1'b0;
      chk("reset_rvalid", 64'(master_rvalid), 64'h0);
      chk("reset_rdata", master_rdata, 64'h0);
      next_cyc();
      rst = 1'b0;

      // Single read of ROM word 4 by M1
      drv(1, 1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
      #3;
      chk("single_gnt", 64'(master_gnt), 64'h2);
      chk("single_slave_req", 64'(slave_req), 64'h1);
      chk("single_slave_addr", 64'(slave_addr[0]), 64'h10);
      next_cyc();
      chk("single_rvalid", 64'(master_rvalid), 64'h2);
      chk("single_rdata", 64'(master_rdata[1]), 64'hA000_0004);
      chk("single_idle_rdata0", 64'(master_rdata[0]), 64'h0);
      drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      next_cyc();
      chk("single_no_stale", 64'(master_rvalid), 64'h0);

      // Parallel: M0 partial write to RAM while M1 reads ROM word 5
      drv(0, 1'b1, 1'b1, 4'b0011, 32'h1000_0004, 32'hDEAD_BEEF);
      drv(1, 1'b1, 1'b0, 4'h0, 32'h0000_0014, 32'h0);
      #3;
      chk("par_gnt", 64'(master_gnt), 64'h3);
      chk("par_slave_req", 64'(slave_req), 64'h3);
      chk("par_ram_wdata", 64'(slave_wdata[1]), 64'hDEAD_BEEF);
      chk("par_ram_be", 64'(slave_be[1]), 64'h3);
      chk("par_ram_we", 64'(slave_we[1]), 64'h1);
      chk("par_rom_addr", 64'(slave_addr[0]), 64'h14);
      next_cyc();
      chk("par_rvalid", 64'(master_rvalid), 64'h3);
      chk("par_rdata1", 64'(master_rdata[1]), 64'hA000_0005);
      drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // Conflict on the RAM word just written; doubles as the readback
      drv(0, 1'b1, 1'b0, 4'h0, 32'h1000_0004, 32'h0);
      drv(1, 1'b1, 1'b0, 4'h0, 32'h1000_0004, 32'h0);
      #3;
      chk("conf_gnt_m0", 64'(master_gnt), 64'h1);
      chk("conf_slave_addr", 64'(slave_addr[1]), 64'h1000_0004);
      next_cyc();
      chk("conf_rvalid_m0", 64'(master_rvalid), 64'h1);
      chk("conf_rdata_m0", 64'(master_rdata[0]), 64'h0000_BEEF);
      drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #3;
      chk("conf_gnt_m1", 64'(master_gnt), 64'h2);
      next_cyc();
      chk("conf_rvalid_m1", 64'(master_rvalid), 64'h2);
      chk("conf_rdata_m1", 64'(master_rdata[1]), 64'h0000_BEEF);
      chk("conf_rdata_m0_idle", 64'(master_rdata[0]), 64'h0);
      drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // Back-to-back ROM reads by M1, words 0..3
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            exp_d = 32'hA000_0000 + 32'(i - 1);
            chk("b2b_rvalid", 64'(master_rvalid), 64'h2);
            chk("b2b_rdata", 64'(master_rdata[1]), 64'(exp_d));
         end
         if (i < 4) begin
            drv(1, 1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0);
            #3;
            chk("b2b_gnt", 64'(master_gnt), 64'h2);
            next_cyc();
         end else begin
            drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         end
      end

      // Decode miss: read, then a dropped write
      drv(0, 1'b1, 1'b0, 4'h0, 32'h2000_0000, 32'h0);
      #3;
      chk("miss_gnt", 64'(master_gnt), 64'h1);
      chk("miss_no_slave_req", 64'(slave_req), 64'h0);
      next_cyc();
      chk("miss_rvalid", 64'(master_rvalid), 64'h1);
      chk("miss_rdata", 64'(master_rdata[0]), 64'h0);
      drv(0, 1'b1, 1'b1, 4'hF, 32'h2000_0000, 32'h1234_5678);
      #3;
      chk("miss_wr_gnt", 64'(master_gnt), 64'h1);
      chk("miss_wr_no_slave_req", 64'(slave_req), 64'h0);
      next_cyc();
      chk("miss_wr_rvalid", 64'(master_rvalid), 64'h1);
      drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      next_cyc();
      chk("miss_rvalid_clear", 64'(master_rvalid), 64'h0);

      // RAM stalls one cycle: gnt must follow the slave
      gnt_block = 2'b10;
      drv(0, 1'b1, 1'b0, 4'h0, 32'h1000_0000, 32'h0);
      #3;
      chk("stall_gnt", 64'(master_gnt), 64'h0);
      chk("stall_slave_req", 64'(slave_req), 64'h2);
      next_cyc();
      chk("stall_no_rvalid", 64'(master_rvalid), 64'h0);
      gnt_block = 2'b00;
      #3;
      chk("stall_release_gnt", 64'(master_gnt), 64'h1);
      next_cyc();
      chk("stall_rvalid", 64'(master_rvalid), 64'h1);
      drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // Reset in the middle of a ROM read: the late slave rvalid must be dropped
      drv(1, 1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_gnt_comb", 64'(master_gnt), 64'h2);
      next_cyc();
      chk("rst_mid_rvalid", 64'(master_rvalid), 64'h0);
      chk("rst_mid_rdata", master_rdata, 64'h0);
      drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      rst = 1'b0;
      #1;
      chk("rst_release_rvalid", 64'(master_rvalid), 64'h0);
      next_cyc();
      chk("rst_after_rvalid", 64'(master_rvalid), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
